// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared types and defaults for the Viterbi decoder back end.
package viterbi_pkg;
   localparam int BLK_LEN_DEF = 32;
   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;
endpackage

// File: rtl/reorder_bank.sv
// reorder_bank: one segment of bit storage with a write port, indexed read and length register.
module reorder_bank
   import viterbi_pkg::*;
#(
   parameter int BLK_LEN = BLK_LEN_DEF,
   parameter int CNT_W   = $clog2(BLK_LEN) + 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we_i,
   input  logic                       close_i,
   input  logic [$clog2(BLK_LEN)-1:0] widx_i,
   input  logic                       wbit_i,
   input  logic [$clog2(BLK_LEN)-1:0] ridx_i,
   output logic                       rbit_o,
   output logic [CNT_W-1:0]           len_o
);
   logic [BLK_LEN-1:0] mem_q;
   logic [CNT_W-1:0]   len_q;
   always_ff @(posedge clk) begin
      if (we_i) mem_q[widx_i] <= wbit_i;
      if (rst) len_q <= '0;
      else if (we_i && close_i) len_q <= {1'b0, widx_i} + CNT_W'(1);
   end
   assign rbit_o = mem_q[ridx_i];
   assign len_o  = len_q;
endmodule

// File: rtl/traceback_bit_reorder.sv
// traceback_bit_reorder: ping-pong buffer replaying newest-first traceback segments oldest-first.
module traceback_bit_reorder
   import viterbi_pkg::*;
#(
   parameter int BLK_LEN = BLK_LEN_DEF,
   parameter int CNT_W   = $clog2(BLK_LEN) + 1
) (
   input  logic clk,
   input  logic rst,
   input  logic tb_valid,
   input  logic tb_bit,
   input  logic tb_last,
   output logic tb_ready,
   input  logic dec_ready,
   output logic dec_bit_valid,
   output logic dec_bit,
   output logic dec_last,
   output logic ovf_err
);
   localparam int AW = $clog2(BLK_LEN);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   bank_state_t      st_q [2];
   bank_state_t      st_d [2];
   logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [AW-1:0]    wcnt_q, wcnt_d;
   logic [CNT_W-1:0] rcnt_q, rcnt_d;
   logic             vld_q, vld_d, bit_q, bit_d, last_q, last_d, ovf_q, ovf_d;
   logic [1:0]       rbit;
   logic [CNT_W-1:0] len [2];
   logic [AW-1:0]    ridx;
   logic             wr_en, closing, done, rd_nxt, can_load;
   assign tb_ready = st_q[wr_bank_q] inside {EMPTY, FILLING};
   assign wr_en    = tb_valid && tb_ready;
   assign closing  = wr_en && (tb_last || wcnt_q == AW'(BLK_LEN - 1));
   assign done     = vld_q && last_q && dec_ready;
   assign rd_nxt   = rd_bank_q ^ done;
   assign can_load = !vld_q || dec_ready;
   assign ridx     = (st_q[rd_nxt] == FULL) ? AW'(len[rd_nxt] - ONE) : AW'(rcnt_q - ONE);
   for (genvar g = 0; g < 2; g++) begin : g_bank
      reorder_bank #(.BLK_LEN(BLK_LEN), .CNT_W(CNT_W)) u_bank (
         .clk(clk), .rst(rst), .we_i(wr_en && wr_bank_q == 1'(g)), .close_i(closing),
         .widx_i(wcnt_q), .wbit_i(tb_bit), .ridx_i(ridx), .rbit_o(rbit[g]), .len_o(len[g])
      );
   end
   always_comb begin
      st_d      = st_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wcnt_d    = wcnt_q;
      rcnt_d    = rcnt_q;
      vld_d     = vld_q;
      bit_d     = bit_q;
      last_d    = last_q;
      ovf_d     = ovf_q | (tb_valid & ~tb_ready);
      if (wr_en) begin
         wcnt_d           = closing ? '0 : wcnt_q + AW'(1);
         st_d[wr_bank_q]  = closing ? FULL : FILLING;
         wr_bank_d        = wr_bank_q ^ closing;
      end
      if (done) begin
         st_d[rd_bank_q] = EMPTY;
         rd_bank_d       = rd_nxt;
      end
      // A segment closing into the read bank forwards its newest write straight to the output
      if (can_load) begin
         vld_d = 1'b0;
         if (st_q[rd_nxt] == FULL) begin
            vld_d        = 1'b1;
            bit_d        = rbit[rd_nxt];
            last_d       = len[rd_nxt] == ONE;
            rcnt_d       = len[rd_nxt] - ONE;
            st_d[rd_nxt] = DRAINING;
         end else if (st_q[rd_nxt] == DRAINING && rcnt_q != '0) begin
            vld_d  = 1'b1;
            bit_d  = rbit[rd_nxt];
            last_d = rcnt_q == ONE;
            rcnt_d = rcnt_q - ONE;
         end else if (closing && wr_bank_q == rd_nxt) begin
            vld_d        = 1'b1;
            bit_d        = tb_bit;
            last_d       = wcnt_q == '0;
            rcnt_d       = {1'b0, wcnt_q};
            st_d[rd_nxt] = DRAINING;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q      <= '{EMPTY, EMPTY};
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wcnt_q    <= '0;
         rcnt_q    <= '0;
         vld_q     <= 1'b0;
         bit_q     <= 1'b0;
         last_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         st_q      <= st_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wcnt_q    <= wcnt_d;
         rcnt_q    <= rcnt_d;
         vld_q     <= vld_d;
         bit_q     <= bit_d;
         last_q    <= last_d;
         ovf_q     <= ovf_d;
      end
   end
   assign dec_bit_valid = vld_q;
   assign dec_bit       = bit_q;
   assign dec_last      = last_q;
   assign ovf_err       = ovf_q;
endmodule

// File: tb/tb_traceback_bit_reorder.sv
// tb_traceback_bit_reorder: scoreboard bench for the traceback bit reorder buffer.
module tb_traceback_bit_reorder;
   logic clk = 0, rst = 1, tb_valid = 0, tb_bit = 0, tb_last = 0, rdy = 1, chain = 0;
   logic tb_ready, dec_ready, dec_bit_valid, dec_bit, dec_last, ovf_err;
   int checks = 0, errors = 0, gap_cnt = 0, waits = 0;
   logic [1:0] sb [$];
   logic       pk_vld = 0;
   logic [7:0] pk_sr = 0, pk_byte = 0;
   logic [2:0] pk_cnt = 0;
   logic [7:0] bytes_got [$];

   assign dec_ready = chain ? !pk_vld : rdy;

   traceback_bit_reorder dut (
      .clk(clk), .rst(rst), .tb_valid(tb_valid), .tb_bit(tb_bit), .tb_last(tb_last),
      .tb_ready(tb_ready), .dec_ready(dec_ready), .dec_bit_valid(dec_bit_valid),
      .dec_bit(dec_bit), .dec_last(dec_last), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   // Behavioural stand-in for bit_packer_8x with out_ready tied high
   always @(posedge clk) begin
      if (rst || !chain) begin
         pk_vld <= 0;
         pk_cnt <= 0;
      end else begin
         if (pk_vld) begin
            bytes_got.push_back(pk_byte);
            pk_vld <= 0;
         end
         if (dec_bit_valid && dec_ready) begin
            pk_sr  <= {pk_sr[6:0], dec_bit};
            pk_cnt <= pk_cnt + 3'd1;
            if (pk_cnt == 3'd7) begin
               pk_vld  <= 1;
               pk_byte <= {pk_sr[6:0], dec_bit};
            end
         end
      end
   end

   task automatic monitor;
      logic hold, h_bit, h_last;
      logic [1:0] exp;
      hold = 0;
      forever begin
         @(negedge clk);
         if (rst) hold = 0;
         else begin
            if (hold) begin
               checks++;
               if (dec_bit_valid !== 1 || dec_bit !== h_bit || dec_last !== h_last) begin
                  errors++;
                  $display("FAIL hold_stable got v=%b b=%b l=%b required v=1 b=%b l=%b", dec_bit_valid, dec_bit, dec_last, h_bit, h_last);
               end
            end
            if (dec_bit_valid && dec_ready) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_output got b=%b l=%b required none", dec_bit, dec_last);
               end else begin
                  exp = sb.pop_front();
                  if ({dec_bit, dec_last} !== exp) begin
                     errors++;
                     $display("FAIL scoreboard got b=%b l=%b required b=%b l=%b", dec_bit, dec_last, exp[1], exp[0]);
                  end
               end
            end
            if (!dec_bit_valid && dec_ready && sb.size() != 0) gap_cnt++;
            hold   = dec_bit_valid && !dec_ready;
            h_bit  = dec_bit;
            h_last = dec_last;
         end
      end
   endtask

   task automatic send_seg(input logic [31:0] d, input int n);
      int w;
      for (int i = 0; i < n; i++) begin
         w = 0;
         tb_valid = 0;
         while (!tb_ready && w < 300) begin
            @(posedge clk); #1;
            w++;
         end
         if (w > 0) waits++;
         if (w == 300) begin
            checks++;
            errors++;
            $display("FAIL send_wait got tb_ready=%b required 1", tb_ready);
         end
         tb_valid = 1;
         tb_bit   = d[i];
         tb_last  = (i == n - 1);
         @(posedge clk); #1;
      end
      tb_valid = 0;
      tb_last  = 0;
      for (int i = n - 1; i >= 0; i--) sb.push_back({d[i], i == 0});
   endtask

   task automatic wait_drain;
      int w;
      w = 0;
      while ((sb.size() != 0 || dec_bit_valid) && w < 1000) begin
         @(posedge clk); #1;
         w++;
      end
      checks++;
      if (w == 1000) begin
         errors++;
         $display("FAIL drain got pending=%0d required 0", sb.size());
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if ({dec_bit_valid, dec_bit, dec_last, tb_ready, ovf_err} !== 5'b00010) begin
         errors++;
         $display("FAIL %s got v/b/l/rdy/ovf=%b required 00010", name,
                  {dec_bit_valid, dec_bit, dec_last, tb_ready, ovf_err});
      end
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      check_idle("reset_state");
   endtask

   task automatic test_basic;
      rdy = 1;
      send_seg(32'b1000_1101, 8);
      checks++;
      if (dec_bit_valid !== 1 || dec_bit !== 1 || dec_last !== 0) begin
         errors++;
         $display("FAIL basic_latency got v=%b b=%b l=%b required v=1 b=1 l=0", dec_bit_valid, dec_bit, dec_last);
      end
      wait_drain();
   endtask

   task automatic test_back_to_back;
      int g0, w0;
      g0 = gap_cnt;
      w0 = waits;
      rdy = 1;
      repeat (3) send_seg($urandom, 32);
      wait_drain();
      checks++;
      if (gap_cnt != g0) begin
         errors++;
         $display("FAIL b2b_gaps got %0d required 0", gap_cnt - g0);
      end
      checks++;
      if (waits != w0) begin
         errors++;
         $display("FAIL b2b_tb_ready_low got %0d stalls required 0", waits - w0);
      end
      checks++;
      if (ovf_err !== 0) begin
         errors++;
         $display("FAIL b2b_ovf got %b required 0", ovf_err);
      end
   endtask

   task automatic test_stall;
      rdy = 1;
      send_seg($urandom, 32);
      fork
         begin
            repeat (5) @(posedge clk);
            #1 rdy = 0;
         end
      join_none
      send_seg($urandom, 32);
      checks++;
      if (tb_ready !== 0) begin
         errors++;
         $display("FAIL stall_tb_ready got %b required 0", tb_ready);
      end
      tb_valid = 1;
      tb_bit   = 1;
      @(posedge clk); #1;
      tb_valid = 0;
      checks++;
      if (ovf_err !== 1) begin
         errors++;
         $display("FAIL stall_ovf got %b required 1", ovf_err);
      end
      repeat (12) @(posedge clk);
      #1 rdy = 1;
      send_seg($urandom, 8);
      wait_drain();
      checks++;
      if (ovf_err !== 1) begin
         errors++;
         $display("FAIL ovf_sticky got %b required 1", ovf_err);
      end
   endtask

   task automatic test_short_segs;
      rdy = 1;
      send_seg(32'b1, 1);
      send_seg(32'b110, 3);
      wait_drain();
   endtask

   task automatic test_reset_mid;
      rdy = 0;
      send_seg($urandom, 32);
      tb_valid = 1;
      repeat (5) begin
         tb_bit = 1'($urandom);
         @(posedge clk); #1;
      end
      tb_valid = 0;
      rst = 1;
      sb.delete();
      @(posedge clk); #1;
      rst = 0;
      check_idle("reset_mid");
      rdy = 1;
      repeat (3) @(posedge clk);
      #1;
      send_seg(32'b1011, 4);
      checks++;
      if (dec_bit_valid !== 1 || dec_bit !== 1 || dec_last !== 0) begin
         errors++;
         $display("FAIL reset_mid_first got v=%b b=%b l=%b required v=1 b=1 l=0", dec_bit_valid, dec_bit, dec_last);
      end
      wait_drain();
   endtask

   task automatic test_packer;
      logic [63:0] fwd;
      logic [31:0] d;
      int b0;
      fwd = {$urandom, $urandom};
      b0 = bytes_got.size();
      chain = 1;
      for (int s = 0; s < 8; s++) begin
         d = '0;
         for (int i = 0; i < 8; i++) d[i] = fwd[63 - (8 * s + 7 - i)];
         send_seg(d, 8);
      end
      wait_drain();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bytes_got.size() - b0 != 8) begin
         errors++;
         $display("FAIL packer_count got %0d required 8", bytes_got.size() - b0);
      end
      for (int j = 0; j < 8 && b0 + j < bytes_got.size(); j++) begin
         checks++;
         if (bytes_got[b0 + j] !== fwd[63 - 8 * j -: 8]) begin
            errors++;
            $display("FAIL packer_byte%0d got %h required %h", j, bytes_got[b0 + j], fwd[63 - 8 * j -: 8]);
         end
      end
      chain = 0;
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_short_segs();
      test_reset_mid();
      test_packer();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
